// File: rtl/rf_debug_pkg.sv
// Shared types for the register-file debug read-out path.
// Also used by the UART debug framer.
package rf_debug_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    READ,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register range through one read port
// and streams each word out on valid/ready.
module regfile_dump_reader
  import rf_debug_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              wb_hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_wb_hold;
  logic              r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_wb_hold   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cur_addr  <= first_addr;
            r_remaining <= last_addr - first_addr;
            r_busy      <= 1'b1;
            r_wb_hold   <= 1'b1;
            r_state     <= HOLD;
          end
        end
        // Lets any in-flight write-back land before the first read.
        HOLD: r_state <= READ;
        READ: begin
          r_out_data  <= rf_read_data;
          r_out_addr  <= r_cur_addr;
          r_out_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_remaining == '0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cur_addr  <= r_cur_addr + 1'b1;
              r_remaining <= r_remaining - 1'b1;
              r_state     <= READ;
            end
          end
        end
        DONE: begin
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_wb_hold <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_read_addr = r_cur_addr;
  assign out_addr     = r_out_addr;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign wb_hold      = r_wb_hold;
  assign done         = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader.
// Drives and samples on the falling edge.
module tb_regfile_dump_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        wb_hold;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];

  int n_tests;
  int n_fail;

  regfile_dump_reader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .first_addr(first_addr),
    .last_addr(last_addr),
    .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data),
    .wb_hold(wb_hold),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_data(out_data),
    .busy(busy),
    .done(done)
  );

  assign rf_read_data = rf[rf_read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_idle_zero(input string tag);
    n_tests++;
    if ({out_valid, done, busy, wb_hold} !== 4'b0) begin
      n_fail++;
      $display("FAIL %s flags got v%b d%b b%b h%b want 0",
               tag, out_valid, done, busy, wb_hold);
    end
    n_tests++;
    if (out_data !== 32'h0 || out_addr !== 5'h0 ||
        rf_read_addr !== 5'h0) begin
      n_fail++;
      $display("FAIL %s data got %h/%h/%h want 0",
               tag, out_data, out_addr, rf_read_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_release");
  endtask

  task automatic test_single();
    rf[3] = 32'hDEADBEEF;
    out_ready = 1'b1;
    first_addr = 5'd3;
    last_addr = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({busy, wb_hold, out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL single_n1 got b%b h%b v%b want 110",
               busy, wb_hold, out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || rf_read_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL single_n2 got v%b ra%0d want 0/3",
               out_valid, rf_read_addr);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_addr !== 5'd3 ||
        out_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_n3 got v%b a%0d d%h want 1/3/deadbeef",
               out_valid, out_addr, out_data);
    end
    @(negedge clk);
    n_tests++;
    if ({done, busy, wb_hold, out_valid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL single_n4 got d%b b%b h%b v%b want 1110",
               done, busy, wb_hold, out_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({done, busy, wb_hold} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_n5 got d%b b%b h%b want 000",
               done, busy, wb_hold);
    end
  endtask

  // Runs one dump; stalls word stall_idx for stall_len cycles.
  task automatic run_dump(input string tag, input logic [4:0] fa,
                          input logic [4:0] la, input int n,
                          input int stall_idx, input int stall_len);
    int k;
    int c;
    int stalled;
    int exp_done;
    logic [4:0] ea;
    logic [4:0] pa;
    logic [31:0] pd;
    logic pv;
    logic seen_done;
    k = 0;
    c = 0;
    stalled = 0;
    pv = 1'b0;
    pa = '0;
    pd = '0;
    seen_done = 1'b0;
    exp_done = 2 + 2 * n + stall_len;
    first_addr = fa;
    last_addr = la;
    out_ready = 1'b1;
    start = 1'b1;
    while (c < 300 && !seen_done) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (pv && !out_ready) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd) begin
          n_fail++;
          $display("FAIL %s_hold got v%b a%0d d%h want 1/%0d/%h",
                   tag, out_valid, out_addr, out_data, pa, pd);
        end
      end
      out_ready = 1'b1;
      if (out_valid && k == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end
      if (out_valid && out_ready) begin
        ea = fa + k[4:0];
        n_tests++;
        if (k >= n || out_addr !== ea || out_data !== rf[ea]) begin
          n_fail++;
          $display("FAIL %s_word%0d got a%0d d%h want a%0d d%h",
                   tag, k, out_addr, out_data, ea, rf[ea]);
        end
        k++;
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        n_tests++;
        if (c != exp_done || k != n) begin
          n_fail++;
          $display("FAIL %s_done got cyc%0d words%0d want cyc%0d words%0d",
                   tag, c, k, exp_done, n);
        end
      end
      pv = out_valid;
      pa = out_addr;
      pd = out_data;
    end
    if (!seen_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout got no done want done", tag);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, wb_hold, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_idle got b%b h%b d%b want 000",
               tag, busy, wb_hold, done);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
    run_dump("full", 5'd0, 5'd31, 32, -1, 0);
  endtask

  task automatic test_wrap();
    rf[0] = 32'hA5A50000;
    rf[30] = 32'h3030C0DE;
    run_dump("wrap", 5'd30, 5'd1, 4, -1, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) rf[i] = 32'h1000 + i;
    run_dump("bp", 5'd0, 5'd3, 4, 1, 5);
  endtask

  task automatic test_abort();
    int c;
    int bad;
    logic [4:0] ea;
    for (int i = 0; i < 8; i++) rf[i] = 32'hC0DE0000 + i;
    rf[20] = 32'h20202020;
    first_addr = 5'd0;
    last_addr = 5'd7;
    out_ready = 1'b1;
    start = 1'b1;
    for (c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 4) begin
        first_addr = 5'd20;
        last_addr = 5'd20;
        start = 1'b1;
      end
      if (c == 3 || c == 5 || c == 7 || c == 9) begin
        ea = 5'((c - 3) / 2);
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== ea ||
            out_data !== rf[ea]) begin
          n_fail++;
          $display("FAIL abort_word c%0d got v%b a%0d want 1/%0d",
                   c, out_valid, out_addr, ea);
        end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("abort_reset");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || out_valid || busy || wb_hold) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b1;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_backpressure();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
